seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream consumer of the 12-bit device read-back word produced by the memory-mapped Device block in the top level.
- Captures the word on a strobe and holds it in a tear-free shadow register that updates only at frame boundaries.
- Time-multiplexes the word as hex digits onto a common-anode 7-segment display, with inter-digit blanking (anti-ghosting) and optional leading-zero suppression.

Parameters:
- NUM_DIGITS, 3, number of hex digits; data width = 4*NUM_DIGITS.
- SCAN_DIV, 50000, clk cycles each digit is driven (>=1).
- BLANK_CYCLES, 16, clk cycles all anodes are off before each digit (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- data_in  input  4*NUM_DIGITS  word from Device_Read_Data.
- data_valid  input  1  capture strobe for data_in (driven from readEn).
- blank_lz  input  1  1 = suppress leading zero digits.
- an  output  NUM_DIGITS  anode enables, active-low; bit i = digit i, where digit 0 is the least-significant nibble.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse on digit wrap.

Behaviour:
- Reset (reset=0, async) clears all state and outputs:
  - pending=0, pend_flag=0, shadow=0, idx=0, cnt=0, state=BLANK.
  - an=all 1, seg=7'h7F, frame_done=0.
- Capture: in any cycle with data_valid=1, pending<=data_in and pend_flag<=1. The last strobe before a frame boundary wins.
- FSM, two states. All outputs are registered and reflect the current state.
  - BLANK: an=all 1, seg=7'h7F. cnt counts 0..BLANK_CYCLES-1; at the terminal count go to DRIVE and clear cnt.
  - DRIVE: an[idx]=0, all other anode bits 1; seg=decode(shadow nibble idx). cnt counts 0..SCAN_DIV-1.
  - At the DRIVE terminal count go to BLANK and clear cnt.
  - If idx<NUM_DIGITS-1 at that point, idx<=idx+1.
  - Otherwise (boundary): idx<=0, frame_done pulses for 1 cycle, and the shadow update below applies.
- Shadow update at the boundary:
  - If data_valid=1 in the boundary cycle, shadow<=data_in (bypass).
  - Else if pend_flag=1, shadow<=pending.
  - Else shadow is unchanged.
  - pend_flag<=0 in all three cases.
- Frame length = NUM_DIGITS*(BLANK_CYCLES+SCAN_DIV) cycles. First DRIVE of digit 0 after reset release starts at cycle BLANK_CYCLES.
- Leading-zero blanking:
  - When blank_lz=1, digit i>0 shows seg=7'h7F (its anode still asserted) if nibbles i..NUM_DIGITS-1 of shadow are all zero.
  - Digit 0 is always shown.
  - blank_lz is sampled every cycle; no latching.
- Hex decode, active-low:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Invariant: never more than one an bit low in any cycle; an is never low during BLANK.
- Reset asserted mid-frame: outputs go to their reset values immediately (async). After release, the sequence restarts at BLANK, idx=0, shadow=0.
- Counters are sized by $clog2 of the larger of SCAN_DIV/BLANK_CYCLES, with wrap-free terminal compare.

Decomposition:
- Shared package seg7_pkg:
  - State enum {BLANK, DRIVE}.
  - The 16-entry active-low segment constant table.
  - SEG_OFF=7'h7F.
- One combinational sub-module, hex_to_seg7 (4-bit in, 7-bit out, uses the package table), instantiated once on the selected nibble.
- Top-level glue (not part of this block): data_in <- Device_Read_Data, data_valid <- readEn.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=2, NUM_DIGITS=3):
- Reset then idle -> an=3'b111 and seg=7F for cycles 0-1. Cycles 2-5: an=3'b110, seg=40 (digit 0 of shadow=0). Frame length 18 cycles; frame_done high exactly at cycle 17.
- data_valid with 12'h1A3 mid-frame -> current frame still shows 0s. Next frame: digit0 seg=30 (3), digit1 seg=08 (A), digit2 seg=79 (1).
- Strobes 12'h005 then 12'h0F0 in the same frame -> next frame shows 0F0 only. With blank_lz=1: digit2 seg=7F with an=3'b011, digit1=0E, digit0=40.
- data_valid with 12'h777 exactly in the boundary cycle -> the frame starting next shows 777 (bypass); pend_flag=0 afterwards.
- blank_lz=1, shadow=000 -> digits 2 and 1 show seg=7F, digit 0 shows 40. Toggling blank_lz mid-DRIVE changes seg on the next cycle.
- Assert reset during DRIVE of digit1 -> same-cycle an=111, seg=7F, frame_done=0. After release: shadow=0, scan resumes from digit 0 after 2 blank cycles. Continuous check: at most one an bit low in any cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   - scan_state_e : two-state scan FSM encoding (BLANK, DRIVE)
//   - SEG_OFF      : all segments dark (active-low)
//   - SEG7_TABLE   : hex digit -> {g,f,e,d,c,b,a} active-low pattern,
//                    indexed directly by the nibble value
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Packed so that SEG7_TABLE[n] is the pattern for hex value n; the list
  // below is written from entry 15 (F) down to entry 0 (0).
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: purely combinational hex-nibble to active-low 7-segment decoder.
//   hex_i [3:0] : nibble to display
//   seg_o [6:0] : {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_TABLE[hex_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: captures a read-back word into a pending register, moves
// it into a tear-free shadow register only at frame boundaries, and scans the
// shadow as hex digits onto a common-anode display with a blanking gap before
// every digit and optional leading-zero suppression.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   data_in    : word to display (4 bits per digit)
//   data_valid : capture strobe for data_in
//   blank_lz   : 1 = suppress leading zero digits (digit 0 always shown)
//   an         : anode enables, active-low, bit i = digit i (LS nibble = 0)
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   frame_done : one-cycle pulse during the last drive cycle of the frame
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    data_valid,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_done
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;

  logic [3:0]            sel_nib_s;
  logic [6:0]            dec_seg_s;
  logic [NUM_DIGITS-1:0] lz_s;
  logic                  upper_zero_s;

  // State, data and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_flag_q  <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: scan sequencing, capture, and frame-boundary shadow load.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    pending_d   = data_valid ? data_in : pending_q;
    pend_flag_d = data_valid ? 1'b1 : pend_flag_q;

    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end else begin
          state_d = BLANK;
        end
      end
      DRIVE: begin
        if (cnt_q == SCAN_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + IW'(1);
          end else begin
            // Frame boundary: a strobe in this very cycle bypasses pending
            // so the newest word is shown without an extra frame of delay.
            idx_d       = '0;
            pend_flag_d = 1'b0;
            if (data_valid) begin
              shadow_d = data_in;
            end else if (pend_flag_q) begin
              shadow_d = pending_q;
            end else begin
              shadow_d = shadow_q;
            end
          end
        end else begin
          state_d = DRIVE;
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Digit nibble select and leading-zero map, both taken from the next shadow
  // so the registered outputs line up with the registered state.
  always_comb begin
    sel_nib_s    = 4'h0;
    lz_s         = '0;
    upper_zero_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      // lz_s[i] = nibbles i..NUM_DIGITS-1 are all zero
      upper_zero_s = upper_zero_s & (shadow_d[4*i +: 4] == 4'h0);
      lz_s[i]      = upper_zero_s;
      sel_nib_s    = (idx_d == IW'(i)) ? shadow_d[4*i +: 4] : sel_nib_s;
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .hex_i (sel_nib_s),
    .seg_o (dec_seg_s)
  );

  // Output decode from the next state; at most one anode is ever pulled low.
  always_comb begin
    an_d         = '1;
    seg_d        = SEG_OFF;
    frame_done_d = 1'b0;
    if (state_d == DRIVE) begin
      an_d = ~(NUM_DIGITS'(1) << idx_d);
      if (blank_lz && (idx_d != '0) && lz_s[idx_d]) begin
        seg_d = SEG_OFF;
      end else begin
        seg_d = dec_seg_s;
      end
      frame_done_d = (idx_d == IDX_LAST) && (cnt_d == SCAN_LAST);
    end else begin
      an_d         = '1;
      seg_d        = SEG_OFF;
      frame_done_d = 1'b0;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver with
// NUM_DIGITS=3, SCAN_DIV=4, BLANK_CYCLES=2. The reference model tracks only
// the position inside the frame plus shadow/pending contents and derives the
// expected anode/segment pattern arithmetically from that position.
module tb_seg7_scan_driver;

  localparam int N    = 3;
  localparam int S    = 4;
  localparam int B    = 2;
  localparam int SLOT = B + S;
  localparam int FL   = N * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] data_in = 12'h000;
  logic        data_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic [2:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          m_p;
  logic [11:0] m_sh;
  logic [11:0] m_pend;
  bit          m_pf;
  bit          m_blz;
  logic [2:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fd;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (S),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] ref_hex(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_expect();
    int d = m_p / SLOT;
    int w = m_p % SLOT;
    e_fd = (m_p == FL - 1);
    e_an = 3'b111;
    if (w < B) begin
      e_seg = 7'h7F;
    end else begin
      e_an[d] = 1'b0;
      if (m_blz && d > 0 && ((m_sh >> (4 * d)) == 12'h000)) e_seg = 7'h7F;
      else e_seg = ref_hex(m_sh[4*d +: 4]);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_sh = 12'h000; m_pend = 12'h000; m_pf = 0; m_blz = blank_lz;
    model_expect();
  endtask

  // one clock: inputs already driven; model applies the same edge
  task automatic tick();
    @(posedge clk);
    m_blz = blank_lz;
    if (m_p == FL - 1) begin
      if (data_valid) m_sh = data_in;
      else if (m_pf) m_sh = m_pend;
      if (data_valid) m_pend = data_in;
      m_pf = 0;
    end else if (data_valid) begin
      m_pend = data_in;
      m_pf = 1;
    end
    m_p = (m_p + 1) % FL;
    #1;
    model_expect();
  endtask

  // continuous invariant: never more than one anode low
  always @(negedge clk) begin
    if (!$isunknown(an)) begin
      checks++;
      if ($countones(~an) > 1) begin
        failures++;
        $display("FAIL one_hot_an t=%0t an got %b want at most one 0", $time, an);
      end
    end
  end

  task automatic test_reset();
    int fd_cnt = 0;
    int fd_at = -1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (an !== 3'b111 || seg !== 7'h7F || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values an got %b want 111 seg got %h want 7f fd got %b want 0", an, seg, frame_done);
    end
    reset = 1'b1;
    model_reset();
    checks++;
    if (an !== e_an || seg !== e_seg || frame_done !== e_fd) begin
      failures++;
      $display("FAIL reset_cycle0 an got %b want %b seg got %h want %h", an, e_an, seg, e_seg);
    end
    for (int c = 0; c < FL; c++) begin
      tick();
      if (frame_done === 1'b1) begin fd_cnt++; fd_at = m_p; end
      checks++;
      if (an !== e_an || seg !== e_seg || frame_done !== e_fd) begin
        failures++;
        $display("FAIL idle_scan p=%0d an got %b want %b seg got %h want %h fd got %b want %b",
                 m_p, an, e_an, seg, e_seg, frame_done, e_fd);
      end
    end
    checks++;
    if (fd_cnt != 1 || fd_at != 17) begin
      failures++;
      $display("FAIL frame_done_pos got count=%0d at=%0d want count=1 at=17", fd_cnt, fd_at);
    end
  endtask

  task automatic test_capture_mid_frame();
    for (int c = 0; c < 2 * FL; c++) begin
      data_valid = (c == 7);
      data_in = (c == 7) ? 12'h1A3 : 12'($urandom);
      tick();
      data_valid = 1'b0;
      checks++;
      if (an !== e_an || seg !== e_seg || frame_done !== e_fd) begin
        failures++;
        $display("FAIL capture_mid p=%0d an got %b want %b seg got %h want %h fd got %b want %b",
                 m_p, an, e_an, seg, e_seg, frame_done, e_fd);
      end
      if (c == FL + 3 || c == FL + 9 || c == FL + 15) begin
        checks++;
        if (!((c == FL + 3 && an === 3'b110 && seg === 7'h30) ||
              (c == FL + 9 && an === 3'b101 && seg === 7'h08) ||
              (c == FL + 15 && an === 3'b011 && seg === 7'h79))) begin
          failures++;
          $display("FAIL capture_1a3_digit c=%0d an got %b seg got %h", c, an, seg);
        end
      end
    end
  endtask

  task automatic test_last_strobe_wins();
    for (int c = 0; c < 2 * FL; c++) begin
      data_valid = (c == 3) || (c == 10);
      data_in = (c == 3) ? 12'h005 : ((c == 10) ? 12'h0F0 : 12'($urandom));
      blank_lz = (c >= FL);
      tick();
      data_valid = 1'b0;
      checks++;
      if (an !== e_an || seg !== e_seg || frame_done !== e_fd) begin
        failures++;
        $display("FAIL last_strobe p=%0d an got %b want %b seg got %h want %h fd got %b want %b",
                 m_p, an, e_an, seg, e_seg, frame_done, e_fd);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_boundary_bypass();
    for (int c = 0; c < 2 * FL; c++) begin
      data_valid = (c == 5) || (c == FL - 1);
      data_in = (c == 5) ? 12'h0AB : ((c == FL - 1) ? 12'h777 : 12'($urandom));
      tick();
      data_valid = 1'b0;
      checks++;
      if (an !== e_an || seg !== e_seg || frame_done !== e_fd) begin
        failures++;
        $display("FAIL boundary_bypass p=%0d an got %b want %b seg got %h want %h fd got %b want %b",
                 m_p, an, e_an, seg, e_seg, frame_done, e_fd);
      end
    end
  endtask

  task automatic test_reset_mid_drive();
    for (int c = 0; c < FL && m_p != 9; c++) begin
      tick();
      checks++;
      if (an !== e_an || seg !== e_seg || frame_done !== e_fd) begin
        failures++;
        $display("FAIL pre_reset p=%0d an got %b want %b seg got %h want %h", m_p, an, e_an, seg, e_seg);
      end
    end
    checks++;
    if (m_p != 9 || an !== 3'b101) begin
      failures++;
      $display("FAIL reach_digit1 p=%0d an got %b want 101", m_p, an);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (an !== 3'b111 || seg !== 7'h7F || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset an got %b want 111 seg got %h want 7f fd got %b want 0", an, seg, frame_done);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    for (int c = 0; c <= FL; c++) begin
      checks++;
      if (an !== e_an || seg !== e_seg || frame_done !== e_fd) begin
        failures++;
        $display("FAIL post_reset p=%0d an got %b want %b seg got %h want %h fd got %b want %b",
                 m_p, an, e_an, seg, e_seg, frame_done, e_fd);
      end
      if (c < FL) tick();
    end
  endtask

  task automatic test_blank_lz_zero();
    for (int c = 0; c < FL; c++) begin
      blank_lz = (c < FL - 3);
      tick();
      checks++;
      if (an !== e_an || seg !== e_seg || frame_done !== e_fd) begin
        failures++;
        $display("FAIL blank_lz p=%0d blz=%b an got %b want %b seg got %h want %h",
                 m_p, blank_lz, an, e_an, seg, e_seg);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 12 * FL; c++) begin
      data_valid = ($urandom_range(0, 5) == 0);
      data_in = ($urandom_range(0, 2) == 0) ? 12'($urandom_range(0, 15) << (4 * $urandom_range(0, 2)))
                                            : 12'($urandom);
      if ($urandom_range(0, 9) == 0) blank_lz = ~blank_lz;
      tick();
      data_valid = 1'b0;
      checks++;
      if (an !== e_an || seg !== e_seg || frame_done !== e_fd) begin
        failures++;
        $display("FAIL random p=%0d sh=%h an got %b want %b seg got %h want %h fd got %b want %b",
                 m_p, m_sh, an, e_an, seg, e_seg, frame_done, e_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture_mid_frame();
    test_last_strobe_wins();
    test_boundary_bypass();
    test_reset_mid_drive();
    test_blank_lz_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
